// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out serializer.
//   state_t : serializer control state (IDLE, SHIFT)
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : piso_pkg

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load handshake.
// Accepts WIDTH-bit words and streams them one bit per shift_en tick, MSB- or
// LSB-first, with zero-gap back-to-back words and a last-bit flag.
//
// Ports:
//   clk         in   single clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   in_valid    in   producer presents in_data
//   in_ready    out  a word can be accepted this cycle
//   in_data     in   WIDTH-bit parallel word
//   lsb_first   in   bit order captured at acceptance (1 = LSB first)
//   shift_en    in   bit-rate tick; stream advances only when 1
//   sout        out  registered serial data (IDLE_LEVEL when idle)
//   sout_valid  out  sout carries a word bit
//   sout_last   out  sout carries the final bit of the word
//   busy        out  a word is in flight (same as sout_valid)
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             lsb_first,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);
  import piso_pkg::*;

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] load_d;
  logic             sout_q;
  logic             sout_valid_q;
  logic             sout_last_q;

  logic at_last;
  logic accept;
  logic shift_mid;

  assign at_last   = (cnt_q == CNT_LAST);
  assign in_ready  = (state_q == IDLE) || (at_last && shift_en);
  assign accept    = in_valid && in_ready;
  assign shift_mid = (state_q == SHIFT) && shift_en && !at_last;

  // Normalise the word so the next bit to send always sits at the MSB;
  // LSB-first words are bit-reversed once at load time.
  always_comb begin
    load_d = in_data;
    if (lsb_first) begin
      for (int i = 0; i < WIDTH; i++) begin
        load_d[WIDTH-1-i] = in_data[i];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= SHIFT;
            cnt_q        <= '0;
            sout_q       <= load_d[WIDTH-1];
            sout_valid_q <= 1'b1;
            sout_last_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (at_last) begin
              if (accept) begin
                // back-to-back reload: first bit of the new word, no gap
                cnt_q        <= '0;
                sout_q       <= load_d[WIDTH-1];
                sout_valid_q <= 1'b1;
                sout_last_q  <= 1'b0;
              end else begin
                state_q      <= IDLE;
                cnt_q        <= '0;
                sout_q       <= IDLE_LEVEL;
                sout_valid_q <= 1'b0;
                sout_last_q  <= 1'b0;
              end
            end else begin
              cnt_q       <= cnt_q + CNT_W'(1);
              sout_q      <= shreg_q[WIDTH-1];
              sout_last_q <= (cnt_q == CNT_PRE);
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          cnt_q        <= '0;
          sout_q       <= IDLE_LEVEL;
          sout_valid_q <= 1'b0;
          sout_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Shift register holds the bits still to be presented; it carries no
  // reset because the control path decides whether its contents are used.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg_q <= load_d << 1;
    end else if (shift_mid) begin
      shreg_q <= shreg_q << 1;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign busy       = sout_valid_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       lsb_first;
  logic       shift_en;
  logic       sout, sout_valid, sout_last, busy;
  logic       in_ready2, sout2, sout_valid2, sout_last2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lsb_first(lsb_first), .shift_en(shift_en),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .lsb_first(lsb_first), .shift_en(shift_en),
    .sout(sout2), .sout_valid(sout_valid2), .sout_last(sout_last2), .busy(busy2)
  );

  // Reference model: queue of bits still owed on the wire; the head is the
  // bit currently presented. Empty queue means idle.
  logic mq[$];
  logic exp_ready, got_ready;
  logic exp_sout, exp_valid, exp_last;

  function automatic void model_outputs();
    exp_valid = (mq.size() > 0);
    exp_sout  = exp_valid ? mq[0] : 1'b0;
    exp_last  = (mq.size() == 1);
  endfunction

  // One clock cycle: drive on negedge, sample in_ready, advance model on
  // posedge, leave outputs settled #1 after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic lsb,
                     input logic se, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; lsb_first = lsb; shift_en = se; rst = r;
    #1;
    got_ready = in_ready;
    exp_ready = (mq.size() == 0) || (mq.size() == 1 && se);
    @(posedge clk);
    if (r) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && se) void'(mq.pop_front());
      if (v && exp_ready) begin
        for (int i = 0; i < 8; i++) mq.push_back(lsb ? d[i] : d[7-i]);
      end
    end
    model_outputs();
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({sout, sout_valid, sout_last, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0000", {sout, sout_valid, sout_last, busy});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++;
    if (sout2 !== 1'b1) begin errors++; $display("FAIL reset_idle_hi got=%b exp=1", sout2); end
  endtask

  task automatic test_order(input logic lsb, input logic [7:0] exp_bits);
    logic [7:0] got_bits;
    logic [7:0] got_last;
    cyc(1'b1, 8'h96, lsb, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      got_bits[7-i] = sout;
      got_last[7-i] = sout_last;
      checks++;
      if (sout_valid !== 1'b1) begin errors++; $display("FAIL order_valid bit=%0d got=%b exp=1", i, sout_valid); end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (got_bits !== exp_bits) begin errors++; $display("FAIL order_bits lsb=%b got=%b exp=%b", lsb, got_bits, exp_bits); end
    checks++;
    if (got_last !== 8'b0000_0001) begin errors++; $display("FAIL order_last got=%b exp=00000001", got_last); end
    checks++;
    if (sout_valid !== 1'b0 || sout !== 1'b0) begin
      errors++; $display("FAIL order_idle got_valid=%b got_sout=%b exp=0,0", sout_valid, sout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got_bits;
    int ready_pulses = 0;
    int gaps = 0;
    cyc(1'b1, 8'h96, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      got_bits[15-i] = sout;
      if (sout_valid !== 1'b1) gaps++;
      cyc((i < 8), (i < 8) ? 8'h0F : 8'h00, 1'b0, 1'b1, 1'b0);
      if (got_ready) ready_pulses++;
      checks++;
      if (got_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
    end
    checks++;
    if (got_bits !== 16'h960F) begin errors++; $display("FAIL b2b_bits got=%h exp=960f", got_bits); end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL b2b_gap got=%0d exp=0", gaps); end
    // one pulse at the end of each word (the second ends with nothing offered)
    checks++;
    if (ready_pulses !== 2) begin errors++; $display("FAIL b2b_ready_pulses got=%0d exp=2", ready_pulses); end
  endtask

  task automatic test_stall();
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic se;
      logic v;
      se = ((i % 3) == 2);
      v  = (i >= 6);
      cyc(v, 8'h3C, 1'b1, se, 1'b0);
      checks++;
      if (got_ready !== exp_ready) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready); end
      checks++;
      if ({sout, sout_valid, sout_last} !== {exp_sout, exp_valid, exp_last}) begin
        errors++; $display("FAIL stall_out cyc=%0d got=%b exp=%b", i, {sout, sout_valid, sout_last}, {exp_sout, exp_valid, exp_last});
      end
    end
    for (int i = 0; i < 30 && mq.size() > 0; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int residual = 0;
    cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({sout, sout_valid, in_ready} !== 3'b001) begin
      errors++; $display("FAIL rstmid_state got=%b exp=001", {sout, sout_valid, in_ready});
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (sout_valid !== 1'b0 || sout !== 1'b0) residual++;
    end
    checks++;
    if (residual !== 0) begin errors++; $display("FAIL rstmid_residual got=%0d exp=0", residual); end
  endtask

  task automatic test_idle_level();
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b0, i[0], 1'b0);
      if (sout2 !== 1'b1 || sout_valid2 !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL idlehi_before got=%0d bad cycles exp=0", bad); end
    cyc(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sout2, sout_valid2} !== 2'b01) begin errors++; $display("FAIL idlehi_word got=%b exp=01", {sout2, sout_valid2}); end
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({sout2, sout_valid2} !== 2'b10) begin errors++; $display("FAIL idlehi_after got=%b exp=10", {sout2, sout_valid2}); end
  endtask

  task automatic test_idle_accept_noshift();
    int ticks = 0;
    int bad = 0;
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (sout !== 1'b1 || sout_valid !== 1'b1 || sout_last !== 1'b0) bad++;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL noshift_hold got=%0d bad cycles exp=0", bad); end
    while (sout_valid === 1'b1 && ticks < 20) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      ticks++;
    end
    checks++;
    if (ticks !== 8) begin errors++; $display("FAIL noshift_ticks got=%0d exp=8", ticks); end
  endtask

  task automatic test_random();
    int bad_ready = 0;
    int bad_out = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 199) == 0));
      if (rst) continue;
      if (got_ready !== exp_ready) begin
        bad_ready++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, got_ready, exp_ready);
      end
      if ({sout, sout_valid, sout_last, busy} !== {exp_sout, exp_valid, exp_last, exp_valid}) begin
        bad_out++;
        $display("FAIL rand_out cyc=%0d got=%b exp=%b", i, {sout, sout_valid, sout_last, busy},
                 {exp_sout, exp_valid, exp_last, exp_valid});
      end
    end
    checks++;
    if (bad_ready !== 0) errors++;
    checks++;
    if (bad_out !== 0) errors++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; lsb_first = 1'b0; shift_en = 1'b0;
    test_reset();
    test_order(1'b0, 8'b1001_0110);
    test_order(1'b1, 8'b0110_1001);
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_idle_level();
    test_idle_accept_noshift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule : tb_piso_serializer
